regfile_wb_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two writeback requesters: A (ALU result) and B (memory-load result).
- Drives the select of the 5-bit write-address mux and the 64-bit write-data path into the register file.
- Round-robin on contention; one registered write per cycle.
- Counts contention cycles for performance analysis.

---
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter for the single register-file write port,
//            shared by the ALU (A) and memory-load (B) writeback paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    pri_t r_ptr;
    logic w_contend;

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        w_contend = a_valid & b_valid & ~freeze;
        a_ready   = rst_n & ~freeze & a_valid & (~b_valid | (r_ptr == PRI_A));
        b_ready   = rst_n & ~freeze & b_valid & (~a_valid | (r_ptr == PRI_B));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= PRI_A;
            wr_en        <= 1'b0;
            wr_sel       <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            conflict_cnt <= '0;
        end else begin
            if (w_contend) begin
                r_ptr <= a_ready ? PRI_B : PRI_A;
                if (conflict_cnt != c_cnt_max) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end

            // Writes to register 0 are accepted but never reach the file.
            if (a_ready) begin
                wr_en   <= (a_addr != '0);
                wr_sel  <= 1'b0;
                wr_addr <= a_addr;
                wr_data <= a_data;
            end else if (b_ready) begin
                wr_en   <= (b_addr != '0);
                wr_sel  <= 1'b1;
                wr_addr <= b_addr;
                wr_data <= b_data;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Table-driven directed bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              freeze;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .freeze      (freeze),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        logic        frz;
        logic        av;
        logic [4:0]  aa;
        logic [63:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [63:0] bd;
        logic        e_ar;
        logic        e_br;
        logic        e_en;
        logic        e_sel;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic [3:0]  e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic av, input logic [4:0] aa, input logic [63:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [63:0] bd);
        freeze  = f;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
    endtask

    vec_t vecs[15];
    logic [3:0] ecnt;

    initial begin
        // A = addr 3 / 0xAAAA, B = addr 7 / 0xBBBB in contention entries
        vecs[0]  = '{0,1,5,64'h1234, 0,0,0,        1,0, 1,0,5,64'h1234, 0};
        vecs[1]  = '{0,0,0,0,        0,0,0,        0,0, 0,0,5,64'h1234, 0};
        vecs[2]  = '{0,1,3,64'hAAAA, 1,7,64'hBBBB, 1,0, 1,0,3,64'hAAAA, 1};
        vecs[3]  = '{0,1,3,64'hAAAA, 1,7,64'hBBBB, 0,1, 1,1,7,64'hBBBB, 2};
        vecs[4]  = '{0,1,3,64'hAAAA, 1,7,64'hBBBB, 1,0, 1,0,3,64'hAAAA, 3};
        vecs[5]  = '{0,1,3,64'hAAAA, 1,7,64'hBBBB, 0,1, 1,1,7,64'hBBBB, 4};
        vecs[6]  = '{0,0,0,0,        1,0,64'hFF,   0,1, 0,1,0,64'hFF,   4};
        vecs[7]  = '{0,1,3,64'hAAAA, 1,7,64'hBBBB, 1,0, 1,0,3,64'hAAAA, 5};
        vecs[8]  = '{1,1,3,64'hAAAA, 1,7,64'hBBBB, 0,0, 0,0,3,64'hAAAA, 5};
        vecs[9]  = '{1,1,3,64'hAAAA, 1,7,64'hBBBB, 0,0, 0,0,3,64'hAAAA, 5};
        vecs[10] = '{1,1,3,64'hAAAA, 1,7,64'hBBBB, 0,0, 0,0,3,64'hAAAA, 5};
        vecs[11] = '{0,1,3,64'hAAAA, 1,7,64'hBBBB, 0,1, 1,1,7,64'hBBBB, 6};
        vecs[12] = '{0,0,0,0,        1,9,64'h5555, 0,1, 1,1,9,64'h5555, 6};
        vecs[13] = '{0,1,3,64'hAAAA, 1,7,64'hBBBB, 1,0, 1,0,3,64'hAAAA, 7};
        vecs[14] = '{0,1,0,64'h77,   0,0,0,        1,0, 0,0,0,64'h77,   7};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rst_wr_en",   {63'd0, wr_en},        64'd0);
        check("rst_wr_sel",  {63'd0, wr_sel},       64'd0);
        check("rst_wr_addr", {59'd0, wr_addr},      64'd0);
        check("rst_wr_data", wr_data,               64'd0);
        check("rst_cnt",     {60'd0, conflict_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].frz, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            #1;
            check($sformatf("v%0d_a_ready", i), {63'd0, a_ready}, {63'd0, vecs[i].e_ar});
            check($sformatf("v%0d_b_ready", i), {63'd0, b_ready}, {63'd0, vecs[i].e_br});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wr_en", i),   {63'd0, wr_en},        {63'd0, vecs[i].e_en});
            check($sformatf("v%0d_wr_sel", i),  {63'd0, wr_sel},       {63'd0, vecs[i].e_sel});
            check($sformatf("v%0d_wr_addr", i), {59'd0, wr_addr},      {59'd0, vecs[i].e_addr});
            check($sformatf("v%0d_wr_data", i), wr_data,               vecs[i].e_data);
            check($sformatf("v%0d_cnt", i),     {60'd0, conflict_cnt}, {60'd0, vecs[i].e_cnt});
        end

        // In-flight write survives a freeze raised in the following cycle.
        @(negedge clk);
        drive(0, 1, 3, 64'hAAAA, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 1, 3, 64'hAAAA, 1, 7, 64'hBBBB);
        #1;
        check("frz_inflight_en", {63'd0, wr_en}, 64'd1);
        check("frz_a_ready",     {63'd0, a_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("frz_after_en", {63'd0, wr_en}, 64'd0);

        // Saturation: 20 contended cycles from count 7.
        ecnt = 4'd7;
        @(negedge clk);
        drive(0, 1, 3, 64'hAAAA, 1, 7, 64'hBBBB);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            ecnt = (ecnt == 4'd15) ? 4'd15 : ecnt + 4'd1;
            check($sformatf("sat%0d_cnt", k), {60'd0, conflict_cnt}, {60'd0, ecnt});
        end
        check("sat_final", {60'd0, conflict_cnt}, 64'd15);

        // Pointer now favours B; asynchronous reset mid-cycle must clear it.
        @(negedge clk);
        drive(0, 1, 3, 64'hAAAA, 1, 7, 64'hBBBB);
        #1;
        check("pre_rst_b_ready", {63'd0, b_ready}, 64'd1);
        @(posedge clk);
        #3;
        drive(0, 1, 5, 64'h1234, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("async_wr_en",   {63'd0, wr_en},        64'd0);
        check("async_wr_sel",  {63'd0, wr_sel},       64'd0);
        check("async_wr_addr", {59'd0, wr_addr},      64'd0);
        check("async_wr_data", wr_data,               64'd0);
        check("async_cnt",     {60'd0, conflict_cnt}, 64'd0);
        check("async_a_ready", {63'd0, a_ready},      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 3, 64'hAAAA, 1, 7, 64'hBBBB);
        #1;
        check("post_rst_a_ready", {63'd0, a_ready}, 64'd1);
        check("post_rst_b_ready", {63'd0, b_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("post_rst_wr_sel", {63'd0, wr_sel},       64'd0);
        check("post_rst_cnt",    {60'd0, conflict_cnt}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
